// File: rtl/decimal_key_arbiter_pkg.sv
// Shared constants, FSM state type and the one-hot to BCD encoder used by the
// decimal key arbiter.
package decimal_key_pkg;

  localparam int N_KEYS = 10;
  localparam int BCD_W  = 4;

  typedef enum logic {IDLE, SEND} state_t;

  // Returns the index of the single set bit; any zero or multi-hot input maps to 0.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [N_KEYS-1:0] oh);
    logic [BCD_W-1:0] idx;
    int               ones;
    idx  = '0;
    ones = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (oh[i]) begin
        idx  = BCD_W'(i);
        ones = ones + 1;
      end
    end
    return (ones == 1) ? idx : '0;
  endfunction

endpackage

// File: rtl/decimal_key_arbiter_if.sv
// Key request inputs and BCD valid/ready output bundle of the decimal key arbiter.
interface decimal_key_arbiter_if;
  import decimal_key_pkg::*;

  logic [N_KEYS-1:0] req;
  logic              out_ready;
  logic              overrun_clr;
  logic [BCD_W-1:0]  out_bcd;
  logic              out_valid;
  logic [N_KEYS-1:0] grant;
  logic              overrun;

  // master drives keys and consumes digits; slave is the arbiter itself.
  modport master (
    output req, out_ready, overrun_clr,
    input  out_bcd, out_valid, grant, overrun
  );

  modport slave (
    input  req, out_ready, overrun_clr,
    output out_bcd, out_valid, grant, overrun
  );

endinterface

// File: rtl/decimal_key_arbiter_debouncer.sv
// Per-key debouncer: counts consecutive high samples and pulses press once
// when the count reaches DEBOUNCE_CYCLES; a low sample re-arms it.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic press
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CYCLES);

  logic [3:0] cnt;

  // High on the sample that moves the counter onto LIMIT; a saturated counter stays silent.
  assign press = in && (cnt == LIMIT - 4'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!in) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/decimal_key_arbiter.sv
// Debounces ten digit keys into sticky pending events and serves them round-robin
// as one-hot grants encoded to BCD on a valid/ready output.
module decimal_key_arbiter
  import decimal_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  decimal_key_arbiter_if.slave bus
);

  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] clr_mask;
  logic [N_KEYS-1:0] sel_oh;
  logic [N_KEYS-1:0] grant_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  last;
  logic [BCD_W-1:0]  sel;
  logic              found;
  logic              valid_q;
  logic              overrun_q;
  logic              overrun_set;
  state_t            state;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_deb
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (bus.req[i]),
      .press(press[i])
    );
  end

  // Round-robin search starting just after the last served key, wrapping 9 -> 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      if (!found && pending[(int'(last) + k) % N_KEYS]) begin
        found = 1'b1;
        sel   = BCD_W'((int'(last) + k) % N_KEYS);
      end
    end
    sel_oh = found ? (N_KEYS'(1) << sel) : '0;
  end

  assign clr_mask = (state == IDLE) ? sel_oh : '0;

  // A press landing on a bit cleared this edge re-arms it without counting as overrun.
  assign overrun_set = |(press & pending & ~clr_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      overrun_q <= 1'b0;
      state     <= IDLE;
      last      <= BCD_W'(N_KEYS - 1);
      grant_q   <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | press;

      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= sel_oh;
            bcd_q   <= onehot_to_bcd(sel_oh);
            valid_q <= 1'b1;
            last    <= sel;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            grant_q <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_decimal_key_arbiter.sv
// Scoreboard bench for decimal_key_arbiter: a behavioural key/arbiter model
// queues expected digits and a separate monitor checks each completed handshake.
module tb_decimal_key_arbiter;

  localparam int DC = 4;
  localparam int NK = 10;

  logic clk;
  logic rst_n;

  decimal_key_arbiter_if bus ();

  decimal_key_arbiter #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  int streak [NK];
  bit pend   [NK];
  int m_last;
  bit m_busy;
  int m_digit;
  bit m_ovr;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NK-1:0] key(input int i);
    logic [NK-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Advances the model across the next rising edge using the inputs now driven.
  task automatic model_step();
    bit press [NK];
    bit ovr_set;
    int sel;
    if (!rst_n) begin
      if (m_busy && exp_q.size() > 0) void'(exp_q.pop_back());
      for (int i = 0; i < NK; i++) begin
        streak[i] = 0;
        pend[i]   = 0;
      end
      m_last = 9; m_busy = 0; m_digit = 0; m_ovr = 0;
      return;
    end
    for (int i = 0; i < NK; i++) begin
      if (bus.req[i]) begin
        press[i]  = (streak[i] < DC) && (streak[i] + 1 == DC);
        streak[i] = (streak[i] < DC) ? streak[i] + 1 : DC;
      end else begin
        press[i]  = 0;
        streak[i] = 0;
      end
    end
    if (!m_busy) begin
      sel = -1;
      for (int k = 1; k <= NK; k++)
        if (sel < 0 && pend[(m_last + k) % NK]) sel = (m_last + k) % NK;
      if (sel >= 0) begin
        pend[sel] = 0;
        m_last    = sel;
        m_busy    = 1;
        m_digit   = sel;
        exp_q.push_back(sel);
      end
    end else if (bus.out_ready) begin
      m_busy = 0;
    end
    ovr_set = 0;
    for (int i = 0; i < NK; i++) begin
      if (press[i]) begin
        if (pend[i]) ovr_set = 1;
        pend[i] = 1;
      end
    end
    if (ovr_set) m_ovr = 1;
    else if (bus.overrun_clr) m_ovr = 0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
    check("out_valid", int'(bus.out_valid), int'(m_busy));
    check("overrun", int'(bus.overrun), int'(m_ovr));
    check("out_bcd", int'(bus.out_bcd), m_busy ? m_digit : 0);
    check("grant", int'(bus.grant), m_busy ? (1 << m_digit) : 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  // Monitor: samples the handshake mid-cycle, after inputs for the next edge are set.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_digit: got %0d expected none at %0t", bus.out_bcd, $time);
        end else begin
          e = exp_q.pop_front();
          check("served_digit", int'(bus.out_bcd), e);
          check("served_grant", int'(bus.grant), 1 << e);
        end
      end
    end
  end

  initial begin
    logic [NK-1:0] rq;
    rst_n = 1'b0;
    bus.req = '0;
    bus.out_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    cycles(2);
    rst_n = 1'b1;

    // Glitch shorter than the debounce window.
    bus.req = key(2); cycles(3);
    bus.req = '0;     cycles(6);

    // Single press under backpressure, then one ready cycle.
    bus.req = key(7); cycles(6);
    bus.req = '0;     cycles(3);
    bus.out_ready = 1'b1; cycles(1);
    bus.out_ready = 1'b0; cycles(2);

    // Round-robin from last=7, last=5, last=0.
    bus.out_ready = 1'b1;
    bus.req = key(0) | key(1) | key(5); cycles(5);
    bus.req = '0; cycles(8);
    bus.req = key(0) | key(1) | key(5); cycles(5);
    bus.req = '0; cycles(8);
    bus.req = key(0); cycles(5);
    bus.req = '0; cycles(4);
    bus.req = key(0) | key(1) | key(5); cycles(5);
    bus.req = '0; cycles(8);

    // Wrap-around after serving key 9.
    bus.req = key(9); cycles(5);
    bus.req = '0; cycles(4);
    bus.req = key(9) | key(2); cycles(5);
    bus.req = '0; cycles(6);

    // Overrun and coalescing while digit 3 is stalled.
    bus.out_ready = 1'b0;
    bus.req = key(3); cycles(5);
    bus.req = key(4); cycles(5);
    bus.req = '0;     cycles(2);
    bus.req = key(4); cycles(5);
    bus.req = '0;     cycles(2);
    check("overrun_after_double_press", int'(bus.overrun), 1);
    bus.out_ready = 1'b1; cycles(6);
    bus.overrun_clr = 1'b1; cycles(1);
    bus.overrun_clr = 1'b0;
    check("overrun_after_clr", int'(bus.overrun), 0);
    cycles(2);

    // Held key emits exactly once.
    bus.req = key(1); cycles(20);
    bus.req = '0; cycles(4);

    // Reset while a digit is in flight.
    bus.out_ready = 1'b0;
    bus.req = key(6); cycles(5);
    bus.req = '0; cycles(2);
    rst_n = 1'b0; cycles(1);
    check("valid_after_mid_reset", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1; cycles(10);

    // Randomized keys, backpressure and overrun clears.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      bus.req = rq;
      bus.out_ready = ($urandom_range(1) == 1);
      bus.overrun_clr = ($urandom_range(15) == 0);
      step();
    end

    // Drain everything still pending.
    bus.req = '0;
    bus.overrun_clr = 1'b0;
    bus.out_ready = 1'b1;
    cycles(40);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
